// File: rtl/bp_pkg.sv
// Shared counter encodings and index helpers for the branch predictor.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [1:0] sat_update(logic [1:0] ctr, logic taken);
    if (taken) return (ctr == ST) ? ST : ctr + 2'd1;
    return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

  // Word-aligned index field: the 'bits' bits starting at address bit 2.
  function automatic logic [31:0] word_field(logic [63:0] addr, int unsigned bits);
    logic [63:0] mask;
    mask = (64'd1 << bits) - 64'd1;
    return 32'((addr >> 2) & mask);
  endfunction

endpackage

// File: rtl/branch_predict_sa_if.sv
// Fetch-side lookup and EX-side update bus of the branch predictor.
interface branch_predict_sa_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int GHR_WIDTH  = 10
);
  // No valid/ready: a lookup is issued on every cycle through next_pc and its
  // result is valid one cycle later against pc; branch_ex is an update strobe
  // that is always accepted in the cycle it is high, so there is no backpressure.
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  flush_btb;
  logic                  predict_taken;
  logic                  predict_hit;
  logic [ADDR_WIDTH-1:0] predict_target_pc;
  logic [GHR_WIDTH-1:0]  predict_ghr;
  logic                  branch_ex;
  logic [ADDR_WIDTH-1:0] branch_pc_ex;
  logic [ADDR_WIDTH-1:0] branch_target_pc;
  logic                  branch_taken_ex;
  logic [GHR_WIDTH-1:0]  branch_ghr_ex;

  modport master (
    output next_pc, pc, flush_btb, branch_ex, branch_pc_ex, branch_target_pc,
           branch_taken_ex, branch_ghr_ex,
    input  predict_taken, predict_hit, predict_target_pc, predict_ghr
  );

  modport slave (
    input  next_pc, pc, flush_btb, branch_ex, branch_pc_ex, branch_target_pc,
           branch_taken_ex, branch_ghr_ex,
    output predict_taken, predict_hit, predict_target_pc, predict_ghr
  );
endinterface

// File: rtl/bp_pht.sv
// Pattern history table of 2-bit saturating counters, bimodal or gshare indexed.
module bp_pht
  import bp_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int PHT_ENTRIES = 1024,
  parameter int GHR_WIDTH   = 10,
  parameter int GSHARE      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rd_pc,
  input  logic [GHR_WIDTH-1:0]  rd_ghr,
  output logic [1:0]            rd_ctr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_pc,
  input  logic [GHR_WIDTH-1:0]  wr_ghr,
  input  logic                  wr_taken
);
  localparam int IW = $clog2(PHT_ENTRIES);
  typedef logic [IW-1:0] idx_t;

  function automatic idx_t pht_index(logic [ADDR_WIDTH-1:0] a, logic [GHR_WIDTH-1:0] h);
    idx_t base;
    base = idx_t'(word_field(64'(a), IW));
    return (GSHARE != 0) ? (base ^ idx_t'(h)) : base;
  endfunction

  logic [1:0] ctr [PHT_ENTRIES];
  idx_t       rd_idx;
  idx_t       wr_idx;

  assign rd_idx = pht_index(rd_pc, rd_ghr);
  assign wr_idx = pht_index(wr_pc, wr_ghr);

  // The read samples the array before this edge's write: read-old, no bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) ctr[i] <= WNT;
      rd_ctr <= SNT;
    end else begin
      rd_ctr <= ctr[rd_idx];
      if (wr_en) ctr[wr_idx] <= sat_update(ctr[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_predict_sa.sv
// Set-associative tagged BTB plus PHT direction predictor with 1-cycle lookup.
module branch_predict_sa
  import bp_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int SET_NUM     = 64,
  parameter int WAYS        = 4,
  parameter int PHT_ENTRIES = 1024,
  parameter int GHR_WIDTH   = 10,
  parameter int GSHARE      = 1
) (
  input logic                cpu_clk,
  input logic                cpu_rst,
  branch_predict_sa_if.slave bus
);
  localparam int SB = $clog2(SET_NUM);
  localparam int VW = (WAYS > 1) ? $clog2(WAYS) : 1;
  typedef logic [SB-1:0] set_t;
  typedef logic [VW-1:0] way_t;

  logic                  btb_valid [SET_NUM][WAYS];
  logic [ADDR_WIDTH-1:0] btb_pc    [SET_NUM][WAYS];
  logic [ADDR_WIDTH-1:0] btb_tgt   [SET_NUM][WAYS];
  way_t                  victim    [SET_NUM];
  logic [GHR_WIDTH-1:0]  ghr;

  // Snapshot of the looked-up set, compared against pc one cycle later.
  logic                  lk_valid [WAYS];
  logic [ADDR_WIDTH-1:0] lk_pc    [WAYS];
  logic [ADDR_WIDTH-1:0] lk_tgt   [WAYS];
  logic [GHR_WIDTH-1:0]  lk_ghr;
  logic [1:0]            lk_ctr;

  set_t lk_set;
  set_t up_set;
  assign lk_set = set_t'(word_field(64'(bus.next_pc), SB));
  assign up_set = set_t'(word_field(64'(bus.branch_pc_ex), SB));

  logic                  hit;
  logic [ADDR_WIDTH-1:0] hit_tgt;

  always_comb begin
    hit     = 1'b0;
    hit_tgt = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && lk_valid[w] && lk_pc[w] == bus.pc) begin
        hit     = 1'b1;
        hit_tgt = lk_tgt[w];
      end
    end
  end

  logic up_hit;
  logic up_free;
  way_t up_hit_way;
  way_t up_free_way;
  way_t up_way;
  logic up_write;
  logic up_use_victim;

  always_comb begin
    up_hit      = 1'b0;
    up_hit_way  = '0;
    up_free     = 1'b0;
    up_free_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!up_hit && btb_valid[up_set][w] && btb_pc[up_set][w] == bus.branch_pc_ex) begin
        up_hit     = 1'b1;
        up_hit_way = way_t'(w);
      end
      if (!up_free && !btb_valid[up_set][w]) begin
        up_free     = 1'b1;
        up_free_way = way_t'(w);
      end
    end
    up_way        = up_hit ? up_hit_way : (up_free ? up_free_way : victim[up_set]);
    up_write      = bus.branch_ex && (up_hit || bus.branch_taken_ex);
    up_use_victim = up_write && !up_hit && !up_free;
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      for (int s = 0; s < SET_NUM; s++) begin
        victim[s] <= '0;
        for (int w = 0; w < WAYS; w++) btb_valid[s][w] <= 1'b0;
      end
      for (int w = 0; w < WAYS; w++) begin
        lk_valid[w] <= 1'b0;
        lk_pc[w]    <= '0;
        lk_tgt[w]   <= '0;
      end
      ghr    <= '0;
      lk_ghr <= '0;
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        lk_valid[w] <= btb_valid[lk_set][w];
        lk_pc[w]    <= btb_pc[lk_set][w];
        lk_tgt[w]   <= btb_tgt[lk_set][w];
      end
      lk_ghr <= ghr;
      if (bus.branch_ex) ghr <= {ghr[GHR_WIDTH-2:0], bus.branch_taken_ex};
      // A flush overrides any allocation made in the same cycle.
      if (bus.flush_btb) begin
        for (int s = 0; s < SET_NUM; s++) begin
          victim[s] <= '0;
          for (int w = 0; w < WAYS; w++) btb_valid[s][w] <= 1'b0;
        end
      end else begin
        if (up_write) btb_valid[up_set][up_way] <= 1'b1;
        if (up_use_victim)
          victim[up_set] <= (victim[up_set] == way_t'(WAYS - 1)) ? '0 : victim[up_set] + way_t'(1);
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst && up_write) begin
      btb_pc[up_set][up_way]  <= bus.branch_pc_ex;
      btb_tgt[up_set][up_way] <= bus.branch_target_pc;
    end
  end

  bp_pht #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PHT_ENTRIES(PHT_ENTRIES),
    .GHR_WIDTH  (GHR_WIDTH),
    .GSHARE     (GSHARE)
  ) u_pht (
    .clk     (cpu_clk),
    .rst     (cpu_rst),
    .rd_pc   (bus.next_pc),
    .rd_ghr  (ghr),
    .rd_ctr  (lk_ctr),
    .wr_en   (bus.branch_ex),
    .wr_pc   (bus.branch_pc_ex),
    .wr_ghr  (bus.branch_ghr_ex),
    .wr_taken(bus.branch_taken_ex)
  );

  assign bus.predict_hit       = hit;
  assign bus.predict_taken     = hit && lk_ctr[1];
  assign bus.predict_target_pc = hit_tgt;
  assign bus.predict_ghr       = lk_ghr;

endmodule

// File: tb/tb_branch_predict_sa.sv
// Bench for branch_predict_sa: bimodal and gshare instances share one stimulus stream.
module tb_branch_predict_sa;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] next_pc = '0;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic        br = 1'b0;
  logic [31:0] bpc = '0;
  logic [31:0] btgt = '0;
  logic        btk = 1'b0;
  logic [9:0]  bghr = '0;

  always #5 clk = ~clk;

  branch_predict_sa_if #(.ADDR_WIDTH(32), .GHR_WIDTH(10)) bus0 ();
  branch_predict_sa_if #(.ADDR_WIDTH(32), .GHR_WIDTH(10)) bus1 ();

  assign bus0.next_pc = next_pc;          assign bus1.next_pc = next_pc;
  assign bus0.pc = pc;                    assign bus1.pc = pc;
  assign bus0.flush_btb = flush;          assign bus1.flush_btb = flush;
  assign bus0.branch_ex = br;             assign bus1.branch_ex = br;
  assign bus0.branch_pc_ex = bpc;         assign bus1.branch_pc_ex = bpc;
  assign bus0.branch_target_pc = btgt;    assign bus1.branch_target_pc = btgt;
  assign bus0.branch_taken_ex = btk;      assign bus1.branch_taken_ex = btk;
  assign bus0.branch_ghr_ex = bghr;       assign bus1.branch_ghr_ex = bghr;

  branch_predict_sa #(.GSHARE(0)) dut0 (.cpu_clk(clk), .cpu_rst(rst), .bus(bus0.slave));
  branch_predict_sa #(.GSHARE(1)) dut1 (.cpu_clk(clk), .cpu_rst(rst), .bus(bus1.slave));

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // BTB contents do not depend on the PHT indexing mode, so one BTB model serves both.
  int          m_ctr [2][1024];
  logic        m_v   [64][4];
  logic [31:0] m_pc  [64][4];
  logic [31:0] m_tg  [64][4];
  int          m_vic [64];
  logic [9:0]  m_ghr = '0;
  logic        s_v   [4];
  logic [31:0] s_pc  [4];
  logic [31:0] s_tg  [4];
  int          s_ctr [2];
  logic [9:0]  s_ghr = '0;

  function automatic int pidx(int g, logic [31:0] a, logic [9:0] h);
    int i;
    i = int'((a >> 2) % 1024);
    if (g == 1) i = i ^ int'(h);
    return i;
  endfunction

  task automatic model_btb_update();
    int set, hw, fw;
    set = int'((bpc >> 2) % 64);
    hw = -1;
    for (int w = 0; w < 4; w++) if (hw < 0 && m_v[set][w] && m_pc[set][w] == bpc) hw = w;
    if (hw >= 0) m_tg[set][hw] = btgt;
    else if (btk) begin
      fw = -1;
      for (int w = 0; w < 4; w++) if (fw < 0 && !m_v[set][w]) fw = w;
      if (fw < 0) begin
        fw = m_vic[set];
        m_vic[set] = (m_vic[set] + 1) % 4;
      end
      m_v[set][fw] = 1'b1;
      m_pc[set][fw] = bpc;
      m_tg[set][fw] = btgt;
    end
  endtask

  task automatic model_step();
    int set, i;
    if (rst) begin
      for (int g = 0; g < 2; g++) for (int k = 0; k < 1024; k++) m_ctr[g][k] = 1;
      for (int s = 0; s < 64; s++) begin
        m_vic[s] = 0;
        for (int w = 0; w < 4; w++) m_v[s][w] = 1'b0;
      end
      for (int w = 0; w < 4; w++) s_v[w] = 1'b0;
      m_ghr = '0;
      s_ghr = '0;
    end else begin
      set = int'((next_pc >> 2) % 64);
      for (int w = 0; w < 4; w++) begin
        s_v[w] = m_v[set][w];
        s_pc[w] = m_pc[set][w];
        s_tg[w] = m_tg[set][w];
      end
      for (int g = 0; g < 2; g++) s_ctr[g] = m_ctr[g][pidx(g, next_pc, m_ghr)];
      s_ghr = m_ghr;
      if (br) begin
        for (int g = 0; g < 2; g++) begin
          i = pidx(g, bpc, bghr);
          m_ctr[g][i] = btk ? ((m_ctr[g][i] < 3) ? m_ctr[g][i] + 1 : 3)
                            : ((m_ctr[g][i] > 0) ? m_ctr[g][i] - 1 : 0);
        end
        if (!flush) model_btb_update();
        m_ghr = {m_ghr[8:0], btk};
      end
      if (flush)
        for (int s = 0; s < 64; s++) begin
          m_vic[s] = 0;
          for (int w = 0; w < 4; w++) m_v[s][w] = 1'b0;
        end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic        c_hit;
  logic [31:0] c_tg;
  int          c_nm;

  always @(negedge clk) begin
    if (chk_en) begin
      c_hit = 1'b0;
      c_tg  = '0;
      c_nm  = 0;
      for (int w = 0; w < 4; w++) begin
        if (s_v[w] && s_pc[w] == pc) begin
          c_nm++;
          if (!c_hit) begin
            c_hit = 1'b1;
            c_tg  = s_tg[w];
          end
        end
      end
      assert (c_nm <= 1) else $error("multiple BTB ways match pc 0x%0h", pc);
      check("cmp_hit0", 32'(bus0.predict_hit), 32'(c_hit));
      check("cmp_hit1", 32'(bus1.predict_hit), 32'(c_hit));
      check("cmp_tgt0", bus0.predict_target_pc, c_tg);
      check("cmp_tgt1", bus1.predict_target_pc, c_tg);
      check("cmp_tk0", 32'(bus0.predict_taken), 32'(c_hit && s_ctr[0] >= 2));
      check("cmp_tk1", 32'(bus1.predict_taken), 32'(c_hit && s_ctr[1] >= 2));
      check("cmp_ghr0", 32'(bus0.predict_ghr), 32'(s_ghr));
      check("cmp_ghr1", 32'(bus1.predict_ghr), 32'(s_ghr));
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs hold through the edge; afterwards pc takes the address just looked up.
  task automatic cycle(input logic [31:0] npc, input logic b, input logic [31:0] bp,
                       input logic [31:0] bt, input logic tk, input logic fl, input logic r);
    next_pc = npc; br = b; bpc = bp; btgt = bt; btk = tk; flush = fl; rst = r;
    bghr = m_ghr;
    @(posedge clk);
    model_step();
    #1;
    pc = next_pc; br = 1'b0; flush = 1'b0; rst = 1'b0;
    #1;
  endtask

  task automatic lookup(input logic [31:0] a);
    cycle(a, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] a, input logic [31:0] t, input logic tk);
    cycle(32'h0, 1'b1, a, t, tk, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(32'h0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    do_reset();
    do_reset();
    chk_en = 1'b1;
    check("rst_hit", 32'(bus0.predict_hit), 32'd0);
    check("rst_ghr", 32'(bus1.predict_ghr), 32'd0);

    lookup(32'h100);
    check("cold_hit", 32'(bus0.predict_hit), 32'd0);
    check("cold_tk", 32'(bus0.predict_taken), 32'd0);
    check("cold_tgt", bus0.predict_target_pc, 32'd0);

    // Bimodal counter walk at 0x200: 01 -> 10 -> 11 -> 11.
    upd(32'h200, 32'h400, 1'b1);
    lookup(32'h200);
    check("walk1_tk", 32'(bus0.predict_taken), 32'd1);
    upd(32'h200, 32'h400, 1'b1);
    upd(32'h200, 32'h400, 1'b1);
    lookup(32'h200);
    check("walk_hit", 32'(bus0.predict_hit), 32'd1);
    check("walk_tgt", bus0.predict_target_pc, 32'h400);
    check("walk_tk", 32'(bus0.predict_taken), 32'd1);
    check("walk_tgt_gs", bus1.predict_target_pc, 32'h400);

    // Update and lookup of the same entry in one cycle: old target first.
    cycle(32'h200, 1'b1, 32'h200, 32'h500, 1'b1, 1'b0, 1'b0);
    check("rdold_tgt", bus0.predict_target_pc, 32'h400);
    lookup(32'h200);
    check("rdnew_tgt", bus0.predict_target_pc, 32'h500);
    upd(32'h200, 32'h500, 1'b0);
    lookup(32'h200);
    check("sat_tk", 32'(bus0.predict_taken), 32'd1);
    upd(32'h200, 32'h500, 1'b0);
    lookup(32'h200);
    check("dec_tk", 32'(bus0.predict_taken), 32'd0);
    check("dec_hit", 32'(bus0.predict_hit), 32'd1);

    // Five taken branches into set 0: the fifth evicts way 0 (0x1000).
    do_reset();
    for (int k = 0; k < 5; k++) upd(32'h1000 + 32'(k) * 32'h100, 32'h2000 + 32'(k) * 32'h4, 1'b1);
    lookup(32'h1000);
    check("evict_miss", 32'(bus0.predict_hit), 32'd0);
    lookup(32'h1100);
    check("keep_hit", 32'(bus0.predict_hit), 32'd1);
    check("keep_tgt", bus0.predict_target_pc, 32'h2004);
    lookup(32'h1400);
    check("new_tgt", bus1.predict_target_pc, 32'h2010);

    // Alternating T/N at 0x300 with the carried history on the gshare instance.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      lookup(32'h300);
      if (i >= 12) begin
        check("gshare_dir", 32'(bus1.predict_taken), 32'((i % 2) == 0));
        check("gshare_hit", 32'(bus1.predict_hit), 32'd1);
      end
      upd(32'h300, 32'h800, (i % 2) == 0);
    end

    // Flush with a same-cycle taken update: lookup in that cycle sees old data.
    cycle(32'h300, 1'b1, 32'h600, 32'h900, 1'b1, 1'b1, 1'b0);
    check("flush_old_hit", 32'(bus0.predict_hit), 32'd1);
    check("flush_old_tgt", bus0.predict_target_pc, 32'h800);
    lookup(32'h300);
    check("flush_miss300", 32'(bus0.predict_hit), 32'd0);
    lookup(32'h600);
    check("flush_miss600", 32'(bus0.predict_hit), 32'd0);
    // 0x600 counter went 01 -> 10 in the flush cycle; T then N leaves it at 10.
    upd(32'h600, 32'h900, 1'b1);
    upd(32'h600, 32'h900, 1'b0);
    lookup(32'h600);
    check("flush_pht_hit", 32'(bus0.predict_hit), 32'd1);
    check("flush_pht_tk", 32'(bus0.predict_taken), 32'd1);

    // Reset mid-stream discards the same-cycle update.
    cycle(32'h600, 1'b1, 32'h700, 32'hA00, 1'b1, 1'b0, 1'b1);
    check("mrst_hit", 32'(bus0.predict_hit), 32'd0);
    check("mrst_tgt", bus0.predict_target_pc, 32'd0);
    check("mrst_ghr", 32'(bus1.predict_ghr), 32'd0);
    lookup(32'h700);
    check("mrst_miss700", 32'(bus0.predict_hit), 32'd0);
    check("mrst_ghr_kept0", 32'(bus0.predict_ghr), 32'd0);
    lookup(32'h600);
    check("mrst_miss600", 32'(bus1.predict_hit), 32'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predict_sa.md
Name: branch_predict_sa

Overview:
- Parametrised next-generation branch predictor for the core fetch stage.
- Combines an N-way set-associative tagged branch target buffer (BTB) with a separate pattern history table (PHT) of 2-bit counters.
- PHT indexing is either plain PC-indexed (bimodal) or gshare (PC xor global history).
- Lookup is issued with next_pc; the result is valid one cycle later against pc. Updates come from the EX stage.

Parameters:
- ADDR_WIDTH, 32, PC / target width.
- SET_NUM, 64, BTB sets; power of 2, ≥2.
- WAYS, 4, BTB associativity; power of 2, 1..8.
- PHT_ENTRIES, 1024, number of 2-bit counters; power of 2.
- GHR_WIDTH, 10, global history length; ≤ log2(PHT_ENTRIES).
- GSHARE, 1, 1 = PHT index is pc_idx xor ghr; 0 = pc_idx only (ghr still maintained).

Ports:
- cpu_clk  in  1  core clock
- cpu_rst  in  1  synchronous active-high reset
- next_pc  in  ADDR_WIDTH  lookup address, sampled every cycle
- pc  in  ADDR_WIDTH  fetch PC, compared against the stored tag/PC of the cycle-earlier lookup
- flush_btb  in  1  invalidate all BTB entries
- predict_taken  out  1  hit && counter[1]
- predict_hit  out  1  tagged BTB hit
- predict_target_pc  out  ADDR_WIDTH  target from the hitting way (0 on miss)
- predict_ghr  out  GHR_WIDTH  GHR used for this lookup; carried down the pipe
- branch_ex  in  1  conditional branch resolved in EX (update strobe)
- branch_pc_ex  in  ADDR_WIDTH  PC of the resolved branch
- branch_target_pc  in  ADDR_WIDTH  resolved target
- branch_taken_ex  in  1  resolved direction
- branch_ghr_ex  in  GHR_WIDTH  predict_ghr that travelled with the branch

Behaviour:
- Reset (cpu_rst = 1 at a clock edge):
  - All valid bits 0; all PHT counters 2'b01 (weakly not-taken).
  - GHR = 0; round-robin victim pointers = 0; lookup registers cleared.
  - Outputs the cycle after reset: predict_hit = 0, predict_taken = 0, predict_target_pc = 0, predict_ghr = 0.
  - Reset asserted mid-operation discards any same-cycle update.
- Index fields:
  - set_idx = pc[log2(SET_NUM)+1 : 2].
  - Full PC stored per entry; no partial tags, so no aliasing hits.
  - pht_idx = pc[log2(PHT_ENTRIES)+1 : 2], xor zero-extended GHR when GSHARE = 1.
- Lookup, fixed latency 1:
  - Cycle t: read set set_idx(next_pc), PHT[pht_idx(next_pc, ghr)], and register the current GHR.
  - Cycle t+1: predict_hit = OR over ways of (valid && stored_pc == pc).
  - predict_target_pc comes from the hitting way; predict_ghr is the registered GHR.
  - At most one way can match, because allocation only occurs on a miss. If multiple ways match, the lowest way wins (assertion in the bench).
- Update, when branch_ex = 1:
  - PHT[pht_idx(branch_pc_ex, branch_ghr_ex)] saturating inc if taken, dec otherwise (00..11, no wrap).
  - GHR <= {GHR[GHR_WIDTH-2:0], branch_taken_ex}. The GHR is non-speculative.
  - BTB hit on branch_pc_ex: overwrite that way's target with branch_target_pc.
  - BTB miss and taken: allocate the lowest invalid way of the set. If the set is full, allocate the victim_ptr[set] way and then victim_ptr[set] += 1 mod WAYS.
  - BTB miss and not taken: no allocation.
- Simultaneous events:
  - Lookup and update in the same cycle to the same set or counter: the lookup returns pre-update contents (read-old, no bypass).
  - flush_btb together with branch_ex: flush wins for valid bits; the PHT/GHR update still occurs.
  - A flush clears valid bits and victim pointers in one cycle; the lookup issued in that cycle still returns old data.
- The PHT and BTB storage are plain registered arrays. No multicycle FSM: one update per cycle, always accepted (no backpressure).

Decomposition:
- Shared package bp_pkg holds:
  - counter encodings SNT = 00, WNT = 01, WT = 10, ST = 11;
  - the sat_update function;
  - index helper functions.
- One sub-module, bp_pht: the PHT array, gshare indexing, and saturating update.
- The BTB ways, victim pointers and GHR stay in the top module.

Test Plan:
- Reset, then next_pc = 0x100 and pc = 0x100 on the following cycle -> predict_hit = 0, predict_taken = 0, predict_target_pc = 0.
- GSHARE = 0: three taken branch_ex at 0x200 -> target 0x400, then lookup 0x200 -> hit = 1, target = 0x400, counter walks 01 → 10 → 11 → 11, predict_taken = 1.
- WAYS = 4: taken branches at 0x1000, 0x1100, 0x1200, 0x1300, 0x1400 (same set, SET_NUM = 64) -> the fifth replaces way 0; lookup 0x1000 misses, lookup 0x1100 hits.
- GSHARE = 1, alternating T/N/T/N branch at 0x300 over 20 iterations with the carried ghr -> after warm-up, predict_taken matches the actual outcome on every iteration.
- Update to 0x200 (taken, new target 0x500) in the same cycle as next_pc = 0x200 -> next cycle shows the old target 0x400; the following lookup shows 0x500.
- flush_btb asserted together with branch_ex at 0x600 taken -> all subsequent lookups miss; the 0x600 PHT counter still incremented; cpu_rst mid-stream zeroes the outputs next cycle.
